// File: rtl/wrr_arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Also usable by other arbiters.
package wrr_arb_pkg;

  localparam int MAX_REQ = 256;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned onehot2idx(input logic [MAX_REQ-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: the lowest set bit at or after ptr wins,
// with wrap-around.
module fixed_prioritizer #(
  parameter int W = 8
) (
  input  logic [W-1:0] req,
  output logic [W-1:0] gnt
);
  assign gnt = req & (-req);
endmodule

module rr_pick
  import wrr_arb_pkg::*;
#(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] cand,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_onehot
);
  logic [NUM_REQ-1:0] rot_cand;
  logic [NUM_REQ-1:0] rot_gnt;

  // Rotate so cand[ptr] sits at bit 0, pick lowest, rotate back.
  assign rot_cand = NUM_REQ'({cand, cand} >> ptr);

  fixed_prioritizer #(.W(NUM_REQ)) u_fixed (
    .req (rot_cand),
    .gnt (rot_gnt)
  );

  assign gnt_onehot = NUM_REQ'(({rot_gnt, rot_gnt} << ptr) >> NUM_REQ);
endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with per-requestor burst credits and
// optional burst locking. Grant is combinational; state moves on fire.
//   state  | meaning
//   IDLE   | arbitrate each cycle among requestors (credit-eligible first)
//   LOCKED | hold grant on owner until its req_last beat fires
module wrr_arbiter
  import wrr_arb_pkg::*;
#(
  parameter int NUM_REQ  = 8,
  parameter int WEIGHT_W = 4,
  parameter int LOCK_EN  = 1
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*WEIGHT_W-1:0]   weight,
  input  logic                          gnt_rdy,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          gnt_vld,
  output logic [$clog2(NUM_REQ)-1:0]    gnt_idx
);
  localparam int IDX_W = clog2_min1(NUM_REQ);

  lock_state_e         lock_q, lock_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [WEIGHT_W-1:0] cred_q [NUM_REQ];
  logic [WEIGHT_W-1:0] cred_d [NUM_REQ];
  logic [WEIGHT_W-1:0] weff   [NUM_REQ];

  logic [NUM_REQ-1:0]  elig, cand, pick_gnt;
  logic [IDX_W-1:0]    win;
  logic [WEIGHT_W-1:0] new_cw;
  logic                fire;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      weff[i] = (weight[i*WEIGHT_W +: WEIGHT_W] == '0) ? WEIGHT_W'(1)
                                                     : weight[i*WEIGHT_W +: WEIGHT_W];
      elig[i] = req[i] & (cred_q[i] != '0);
    end
    cand = (elig != '0) ? elig : req;
  end

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .cand       (cand),
    .ptr        (ptr_q),
    .gnt_onehot (pick_gnt)
  );

  always_comb begin
    gnt = pick_gnt;
    if (lock_q == LOCKED) begin
      gnt = req[owner_q] ? (NUM_REQ'(1) << owner_q) : '0;
    end
  end

  assign gnt_vld = |gnt;
  assign gnt_idx = IDX_W'(onehot2idx(MAX_REQ'(gnt)));
  assign win     = gnt_idx;
  assign fire    = gnt_vld & gnt_rdy;

  always_comb begin
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cred_d  = cred_q;
    new_cw  = '0;
    if (fire) begin
      if ((LOCK_EN != 0) && !req_last[win]) begin
        if (lock_q == IDLE) begin
          lock_d  = LOCKED;
          owner_d = win;
        end
      end else begin
        // Burst end: credits count bursts; an empty winner triggers a reload.
        lock_d = IDLE;
        if (cred_q[win] == '0) begin
          for (int j = 0; j < NUM_REQ; j++) cred_d[j] = weff[j];
          new_cw = weff[win] - WEIGHT_W'(1);
        end else begin
          new_cw = cred_q[win] - WEIGHT_W'(1);
        end
        cred_d[win] = new_cw;
        if (new_cw == '0) begin
          ptr_d = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + IDX_W'(1);
        end else begin
          ptr_d = win;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      lock_q  <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) cred_q[i] <= '0;
    end else begin
      lock_q  <= lock_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      for (int i = 0; i < NUM_REQ; i++) cred_q[i] <= cred_d[i];
    end
  end

endmodule
